wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ASIZE, default 4, address width; FIFO depth = 2^ASIZE; legal range ASIZE >= 2.
REQ-002 SHALL have parameter AFULL_THRESH, default 12, occupancy at or above which walmost_full asserts; legal range 1..2^ASIZE.
REQ-003 SHALL have port wclk  input  1  write clock; all state updates on its rising edge.
REQ-004 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port winc  input  1  write request from the write-side client.
REQ-006 SHALL have port rptr_sync  input  ASIZE+1  read pointer, Gray code, already two-flop synchronized into wclk.
REQ-007 SHALL have port wptr  output  ASIZE+1  registered write pointer, Gray code, to the read-domain synchronizer.
REQ-008 SHALL have port waddr  output  ASIZE  write address to the RAM: the low ASIZE bits of the binary write pointer.
REQ-009 SHALL have port wfull  output  1  registered full flag.
REQ-010 SHALL have port walmost_full  output  1  registered almost-full flag.
REQ-011 SHALL have port wlevel  output  ASIZE+1  registered write-side occupancy estimate, 0..2^ASIZE.
REQ-012 SHALL have port wovf  output  1  sticky overflow flag.
REQ-013 SHALL have port wovf_clr  input  1  synchronous clear for wovf.

Function
REQ-014 SHALL hold the binary pointer wbin (ASIZE+1 bits) and the Gray pointer wptr as registers.
REQ-015 SHALL accept a write only when winc=1 and wfull=0 at the clock edge (wen).
REQ-016 SHALL compute wbin_next = wbin + wen, modulo 2^(ASIZE+1), wrapping silently from all-ones to zero.
REQ-017 SHALL compute wgray_next = (wbin_next >> 1) XOR wbin_next and register it into wptr, so only one wptr bit changes per accepted write.
REQ-018 SHALL drive waddr from the registered wbin; the address of an accepted write is waddr before the edge.
REQ-019 SHALL register wfull = (wgray_next == {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]}).
REQ-020 Given REQ-019, wfull SHALL assert on the same edge as the write that fills the FIFO.
REQ-021 wfull SHALL deassert on the first edge after rptr_sync advances.
REQ-022 SHALL convert rptr_sync to binary rbin: rbin[ASIZE] = rptr_sync[ASIZE]; rbin[i] = rbin[i+1] XOR rptr_sync[i].
REQ-023 SHALL register wlevel = (wbin_next - rbin) modulo 2^(ASIZE+1).
REQ-024 SHALL register walmost_full = ((wbin_next - rbin) >= AFULL_THRESH).
REQ-025 SHALL never let a write be accepted, and SHALL leave wbin, wptr and waddr unchanged, when winc=1 while wfull=1.
REQ-026 SHALL set wovf on the edge following any cycle with winc=1 and wfull=1.
REQ-027 SHALL clear wovf on an edge with wovf_clr=1; when set and clear occur on the same edge, set SHALL win.
REQ-028 SHALL treat a write and a rptr_sync change in the same cycle independently: the flags reflect wbin_next and the new rptr_sync.
REQ-029 SHALL contain no combinational path from any input to any output.

Reset
REQ-030 On wrst_n=0, SHALL immediately clear wbin, wptr, waddr, wfull, walmost_full, wlevel and wovf to 0, independent of wclk.
REQ-031 SHALL release reset synchronously with respect to wclk (external requirement).
REQ-032 Reset asserted mid-operation SHALL discard all pointer state; the first write after release SHALL go to waddr=0.

Verification (ASIZE=4, AFULL_THRESH=12)
REQ-033 Reset: assert wrst_n=0 mid-clock -> all outputs 0 before the next wclk edge.
REQ-034 Fill: rptr_sync=0, winc=1 for 16 cycles.
- After 12 writes: walmost_full=1, wlevel=12.
- After 16 writes: wfull=1, wlevel=16, wptr=5'b11000, waddr=0.
REQ-035 Overflow: while full, winc=1 for 1 cycle -> wptr stays 5'b11000 and wovf=1 next edge; a later wovf_clr=1 -> wovf=0; wovf_clr=1 together with winc=1 while full -> wovf stays 1.
REQ-036 Drain: from full, set rptr_sync=5'b00001 (binary 1) -> next edge wfull=0, wlevel=15; then one write -> wfull=1, wptr=gray(17)=5'b11001.
REQ-037 Wrap: 32 accepted writes with rptr_sync tracking, e.g. gray(wbin-8) -> wptr returns to 5'b00000, waddr=0, wfull never asserts, wlevel=8 throughout steady state.
REQ-038 Reset mid-fill: after 5 writes, pulse wrst_n low -> wptr=0, wlevel=0; next accepted write uses waddr=0.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full flags and occupancy estimate for an async FIFO.
// Keeps binary and Gray write pointers and compares them against the synchronized read pointer.
module wptr_full_ctrl #(
  parameter int unsigned ASIZE        = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   rptr_sync,
  input  logic             wovf_clr,
  output logic [ASIZE:0]   wptr,
  output logic [ASIZE-1:0] waddr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf
);

  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next_c;
  logic [PW-1:0] wgray_next_c;
  logic [PW-1:0] rbin_c;
  logic [PW-1:0] level_next_c;
  logic [PW-1:0] rptr_full_c;
  logic          wen_c;
  logic          full_next_c;
  logic          afull_next_c;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar g = 0; g < PW; g++) begin : g_rbin
    assign rbin_c[g] = ^(rptr_sync >> g);
  end

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  always_comb begin
    wen_c        = winc & ~wfull;
    wbin_next_c  = wbin + PW'(wen_c);
    wgray_next_c = (wbin_next_c >> 1) ^ wbin_next_c;
    rptr_full_c  = {~rptr_sync[ASIZE:ASIZE-1], rptr_sync[ASIZE-2:0]};
    full_next_c  = (wgray_next_c == rptr_full_c);
    level_next_c = wbin_next_c - rbin_c;
    afull_next_c = (level_next_c >= PW'(AFULL_THRESH));
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next_c;
      wptr         <= wgray_next_c;
      wfull        <= full_next_c;
      walmost_full <= afull_next_c;
      wlevel       <= level_next_c;
    end
  end

  // Sticky overflow: a rejected write outranks a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

  assign waddr = wbin[ASIZE-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ASIZE=4, AFULL_THRESH=12.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr_sync;
  logic       wovf_clr;
  logic [4:0] wptr;
  logic [3:0] waddr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       clr;
    logic [4:0] e_wptr;
    logic [3:0] e_waddr;
    logic       e_full;
    logic       e_afull;
    logic [4:0] e_level;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  wptr_full_ctrl #(.ASIZE(4), .AFULL_THRESH(12)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr_sync    (rptr_sync),
    .wovf_clr     (wovf_clr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic wi, input logic [4:0] rp, input logic cl,
                              input logic [4:0] ep, input logic [3:0] ea, input logic ef,
                              input logic eaf, input logic [4:0] el, input logic eo);
    vec_t v;
    v.winc = wi; v.rptr = rp; v.clr = cl; v.e_wptr = ep; v.e_waddr = ea;
    v.e_full = ef; v.e_afull = eaf; v.e_level = el; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag, input logic [4:0] ep, input logic [3:0] ea,
                           input logic ef, input logic eaf, input logic [4:0] el, input logic eo);
    check({tag, ".wptr"},  32'(wptr),         32'(ep));
    check({tag, ".waddr"}, 32'(waddr),        32'(ea));
    check({tag, ".wfull"}, 32'(wfull),        32'(ef));
    check({tag, ".afull"}, 32'(walmost_full), 32'(eaf));
    check({tag, ".wlevel"},32'(wlevel),       32'(el));
    check({tag, ".wovf"},  32'(wovf),         32'(eo));
  endtask

  task automatic step(input logic wi, input logic [4:0] rp, input logic cl);
    @(negedge wclk);
    winc = wi; rptr_sync = rp; wovf_clr = cl;
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0; winc = 1'b0; rptr_sync = '0; wovf_clr = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n = 1'b0; winc = 1'b0; rptr_sync = '0; wovf_clr = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    check_all("reset", 5'd0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill, overflow, clear and drain vectors
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(1'b1, 5'd0, 1'b0, gray(5'(k)), 4'(k), k == 16, k >= 12, 5'(k), 1'b0));
    vecs.push_back(mk(1'b1, 5'd0,     1'b0, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0,     1'b1, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b0));
    vecs.push_back(mk(1'b1, 5'd0,     1'b1, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0,     1'b0, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0,     1'b1, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b0));
    vecs.push_back(mk(1'b0, 5'b00001, 1'b0, 5'b11000, 4'd0, 1'b0, 1'b1, 5'd15, 1'b0));
    vecs.push_back(mk(1'b1, 5'b00001, 1'b0, 5'b11001, 4'd1, 1'b1, 1'b1, 5'd16, 1'b0));

    foreach (vecs[i]) begin
      step(vecs[i].winc, vecs[i].rptr, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].e_wptr, vecs[i].e_waddr, vecs[i].e_full,
                vecs[i].e_afull, vecs[i].e_level, vecs[i].e_ovf);
    end

    // Async reset mid-clock while full: outputs clear before the next edge
    @(negedge wclk);
    winc = 1'b0;
    #2 wrst_n = 1'b0;
    #1 check_all("async_rst", 5'd0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Reset mid-fill discards pointer state
    for (int k = 1; k <= 5; k++) step(1'b1, 5'd0, 1'b0);
    check("midfill.wlevel", 32'(wlevel), 32'd5);
    check("midfill.wptr",   32'(wptr),   32'(5'b00111));
    @(negedge wclk);
    winc = 1'b0;
    wrst_n = 1'b0;
    #1 check("midrst.wptr", 32'(wptr), 32'd0);
    check("midrst.wlevel", 32'(wlevel), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
    check("midrst.waddr", 32'(waddr), 32'd0);
    step(1'b1, 5'd0, 1'b0);
    check_all("post_rst_wr", 5'd1, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0);

    // Wrap: 32 writes with the read pointer trailing by 8
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      step(1'b1, (n <= 8) ? 5'd0 : gray(5'(n - 8)), 1'b0);
      check($sformatf("wrap%0d.wptr", n),  32'(wptr),   32'(gray(5'(n))));
      check($sformatf("wrap%0d.wfull", n), 32'(wfull),  32'd0);
      check($sformatf("wrap%0d.wlevel", n),32'(wlevel), (n <= 8) ? 32'(n) : 32'd8);
    end
    check("wrap.wptr_end",  32'(wptr),  32'd0);
    check("wrap.waddr_end", 32'(waddr), 32'd0);
    check("wrap.afull_end", 32'(walmost_full), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
